fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with a small FIFO fetch buffer.
// It fetches sequential words from a combinational instruction memory,
// starting at a given pc. It delivers them in order on a valid/ready
// output and stops after the word at LAST_ADDR has been fetched and
// drained. A redirect flushes the buffer and refetches from a new pc.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, start_pc     begin fetching at start_pc (IDLE only)
//   redirect, redirect_pc  flush the buffer and refetch from redirect_pc
//   imem_addr/imem_instr   word-aligned memory address and its read data
//   out_valid/out_ready    head of the buffer and consumer handshake
//   out_pc, out_instr      address and word at the buffer head
//   busy, done             not-IDLE flag; one-cycle completion pulse
//   fetch_count            instructions delivered since the last start
module fetch_ctrl #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [7:0]  LAST_ADDR = 8'd76
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  start_pc,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pc,
  output logic [31:0] out_instr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  fetch_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } entry_t;

  state_t           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  entry_t           fifo_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       fcnt_q;
  logic             done_q, done_d;
  logic             push, pop, flush, clr_fcnt, full;

  // The low address bits are ignored by design; the name keeps them out of lint.
  logic unused_low_bits;
  assign unused_low_bits = ^{start_pc[1:0], redirect_pc[1:0]};

  assign full = (cnt_q == CNT_W'(DEPTH));
  assign pop  = out_valid & out_ready;

  // Next-state, pc and buffer-control decode.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    push     = 1'b0;
    flush    = 1'b0;
    clr_fcnt = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Redirect acts as a start and its pc wins over start_pc.
        if (redirect) begin
          pc_d     = {redirect_pc[7:2], 2'b00};
          clr_fcnt = 1'b1;
          state_d  = S_RUN;
        end else if (start) begin
          pc_d     = {start_pc[7:2], 2'b00};
          clr_fcnt = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (redirect) begin
          flush = 1'b1;
          pc_d  = {redirect_pc[7:2], 2'b00};
        end else if (!full || pop) begin
          push = 1'b1;
          pc_d = pc_q + 8'd4;
          if (pc_q == LAST_ADDR) begin
            state_d = S_END;
          end
        end
      end
      S_END: begin
        if (redirect) begin
          flush   = 1'b1;
          pc_d    = {redirect_pc[7:2], 2'b00};
          state_d = S_RUN;
        end else if (cnt_q == CNT_W'(pop)) begin
          // Buffer empties on this edge: finish and pulse done.
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pc, buffer and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= 8'd0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      fcnt_q  <= 8'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;

      if (clr_fcnt) begin
        fcnt_q <= 8'd0;
      end else if (pop) begin
        fcnt_q <= fcnt_q + 8'd1;
      end

      if (flush) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (pop) begin
          rd_q <= rd_q + PTR_W'(1);
        end
        if (push) begin
          fifo_q[wr_q] <= '{pc: pc_q, instr: imem_instr};
          wr_q         <= wr_q + PTR_W'(1);
        end
        cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  assign imem_addr   = {pc_q[7:2], 2'b00};
  assign out_valid   = (cnt_q != '0);
  assign out_pc      = fifo_q[rd_q].pc;
  assign out_instr   = fifo_q[rd_q].instr;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: scoreboard of expected {pc, instr} pairs,
// popped and compared whenever the DUT hands an instruction over.
// Instance u_dut uses the default parameters; u_wrap uses DEPTH=4 and
// LAST_ADDR=4 for the address-wrap case.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, redirect, out_ready;
  logic [7:0]  start_pc, redirect_pc;
  logic [7:0]  imem_addr0, out_pc0, fetch_count0;
  logic [31:0] imem_instr0, out_instr0;
  logic        out_valid0, busy0, done0;

  logic        reset1, start1, redirect1, out_ready1;
  logic [7:0]  start_pc1, redirect_pc1;
  logic [7:0]  imem_addr1, out_pc1, fetch_count1;
  logic [31:0] imem_instr1, out_instr1;
  logic        out_valid1, busy1, done1;

  int n_checks = 0;
  int n_fails  = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  logic [39:0] q0 [$];
  logic [39:0] q1 [$];

  // Test program memory image; words beyond the program are tagged filler.
  function automatic logic [31:0] instr_at(input logic [7:0] a);
    case (a)
      8'd0:    return 32'h00007033;
      8'd4:    return 32'h00100093;
      8'd8:    return 32'h00200113;
      8'd12:   return 32'h00308193;
      8'd16:   return 32'h00410213;
      8'd20:   return 32'h00518293;
      8'd24:   return 32'h00620313;
      8'd28:   return 32'h00728393;
      8'd32:   return 32'h00208433;
      8'd36:   return 32'h008404b3;
      8'd40:   return 32'h00948533;
      8'd44:   return 32'h00a505b3;
      8'd48:   return 32'h00b58633;
      8'd52:   return 32'h00c606b3;
      8'd56:   return 32'h00d68733;
      8'd60:   return 32'h00e707b3;
      8'd64:   return 32'h00f78833;
      8'd68:   return 32'h010808b3;
      8'd72:   return 32'h00002583;
      8'd76:   return 32'h03002603;
      default: return 32'hdead0000 | 32'(a);
    endcase
  endfunction

  assign imem_instr0 = instr_at(imem_addr0);
  assign imem_instr1 = instr_at(imem_addr1);

  fetch_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr0), .imem_instr(imem_instr0),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_pc(out_pc0), .out_instr(out_instr0),
    .busy(busy0), .done(done0), .fetch_count(fetch_count0)
  );

  fetch_ctrl #(.DEPTH(4), .LAST_ADDR(8'd4)) u_wrap (
    .clk(clk), .reset(reset1), .start(start1), .start_pc(start_pc1),
    .redirect(redirect1), .redirect_pc(redirect_pc1),
    .imem_addr(imem_addr1), .imem_instr(imem_instr1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_pc(out_pc1), .out_instr(out_instr1),
    .busy(busy1), .done(done1), .fetch_count(fetch_count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Push the expected fetch sequence from first to last (8-bit wrap).
  task automatic expect_seq(input int which, input logic [7:0] first, input logic [7:0] last);
    logic [7:0] a;
    a = first;
    forever begin
      if (which == 0) q0.push_back({a, instr_at(a)});
      else            q1.push_back({a, instr_at(a)});
      if (a == last) break;
      a = a + 8'd4;
    end
  endtask

  // One clock: score pops just before the edge, return #1 after it.
  task automatic tick();
    logic [39:0] e;
    @(negedge clk);
    if (!reset && out_valid0 && out_ready) begin
      if (q0.size() == 0) check("sb0_extra_pop", 32'(q0.size()), 32'd1);
      else begin
        e = q0.pop_front();
        check("sb0_pc", 32'(out_pc0), 32'(e[39:32]));
        check("sb0_instr", out_instr0, e[31:0]);
      end
    end
    if (!reset1 && out_valid1 && out_ready1) begin
      if (q1.size() == 0) check("sb1_extra_pop", 32'(q1.size()), 32'd1);
      else begin
        e = q1.pop_front();
        check("sb1_pc", 32'(out_pc1), 32'(e[39:32]));
        check("sb1_instr", out_instr1, e[31:0]);
      end
    end
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int which, output int n);
    n = 0;
    while (((which == 0) ? busy0 : busy1) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'((which == 0) ? busy0 : busy1), 32'd0);
  endtask

  task automatic begin_run(input logic [7:0] spc);
    start = 1'b1; start_pc = spc;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n, d;
    reset = 1'b1; start = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    start_pc = 8'd0; redirect_pc = 8'd0;
    reset1 = 1'b1; start1 = 1'b0; redirect1 = 1'b0; out_ready1 = 1'b0;
    start_pc1 = 8'd0; redirect_pc1 = 8'd0;
    tick(); tick();
    check("rst_valid", 32'(out_valid0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_count", 32'(fetch_count0), 32'd0);
    check("rst_addr", 32'(imem_addr0), 32'd0);
    check("rst_pc", 32'(out_pc0), 32'd0);
    check("rst_instr", out_instr0, 32'd0);
    reset = 1'b0;

    // Full program, consumer always ready.
    d = done_cnt0;
    out_ready = 1'b1;
    expect_seq(0, 8'd0, 8'd76);
    begin_run(8'd0);
    check("run_busy", 32'(busy0), 32'd1);
    check("run_valid_e0", 32'(out_valid0), 32'd0);
    check("run_addr_e0", 32'(imem_addr0), 32'd0);
    tick();
    check("run_valid_e1", 32'(out_valid0), 32'd1);
    check("run_head_e1", 32'(out_pc0), 32'd0);
    wait_idle(0, n);
    check("run_cycles", 32'(n), 32'd20);
    tick();
    check("run_done", 32'(done_cnt0 - d), 32'd1);
    check("run_count", 32'(fetch_count0), 32'd20);
    check("run_sb_empty", 32'(q0.size()), 32'd0);

    // Backpressure: buffer fills and pc holds.
    d = done_cnt0;
    out_ready = 1'b0;
    expect_seq(0, 8'd0, 8'd76);
    begin_run(8'd0);
    repeat (5) tick();
    check("bp_valid", 32'(out_valid0), 32'd1);
    check("bp_addr", 32'(imem_addr0), 32'd8);
    check("bp_head_pc", 32'(out_pc0), 32'd0);
    check("bp_head_instr", out_instr0, 32'h00007033);
    check("bp_count", 32'(fetch_count0), 32'd0);
    out_ready = 1'b1;
    wait_idle(0, n);
    tick();
    check("bp_done", 32'(done_cnt0 - d), 32'd1);
    check("bp_count_end", 32'(fetch_count0), 32'd20);
    check("bp_sb_empty", 32'(q0.size()), 32'd0);

    // Redirect to 32 while the head is pc 8 and being popped.
    d = done_cnt0;
    expect_seq(0, 8'd0, 8'd8);
    expect_seq(0, 8'd32, 8'd76);
    begin_run(8'd0);
    tick(); tick(); tick();
    check("rd_head8", 32'(out_pc0), 32'd8);
    check("rd_count_pre", 32'(fetch_count0), 32'd2);
    redirect = 1'b1; redirect_pc = 8'd32;
    tick();
    redirect = 1'b0;
    check("rd_count_pop", 32'(fetch_count0), 32'd3);
    check("rd_flushed", 32'(out_valid0), 32'd0);
    check("rd_addr", 32'(imem_addr0), 32'd32);
    tick();
    check("rd_next_pc", 32'(out_pc0), 32'd32);
    check("rd_next_instr", out_instr0, 32'h00208433);
    wait_idle(0, n);
    tick();
    check("rd_done", 32'(done_cnt0 - d), 32'd1);
    check("rd_count_end", 32'(fetch_count0), 32'd15);
    check("rd_sb_empty", 32'(q0.size()), 32'd0);

    // Reset mid-RUN with a full buffer, then a clean restart.
    d = done_cnt0;
    out_ready = 1'b0;
    begin_run(8'd0);
    tick(); tick(); tick();
    check("mr_full", 32'(out_valid0), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_valid", 32'(out_valid0), 32'd0);
    check("mr_busy", 32'(busy0), 32'd0);
    check("mr_addr", 32'(imem_addr0), 32'd0);
    check("mr_pc", 32'(out_pc0), 32'd0);
    check("mr_done", 32'(done0), 32'd0);
    out_ready = 1'b1;
    expect_seq(0, 8'd0, 8'd76);
    begin_run(8'd0);
    wait_idle(0, n);
    tick();
    check("mr_restart_done", 32'(done_cnt0 - d), 32'd1);
    check("mr_restart_count", 32'(fetch_count0), 32'd20);

    // Misaligned start; a start while running is ignored.
    d = done_cnt0;
    expect_seq(0, 8'd4, 8'd76);
    begin_run(8'd7);
    check("mis_addr", 32'(imem_addr0), 32'd4);
    tick(); tick();
    start = 1'b1; start_pc = 8'd40;
    tick();
    start = 1'b0;
    wait_idle(0, n);
    tick();
    check("mis_done", 32'(done_cnt0 - d), 32'd1);
    check("mis_count", 32'(fetch_count0), 32'd19);

    // Redirect in IDLE takes precedence over start.
    d = done_cnt0;
    expect_seq(0, 8'd64, 8'd76);
    start = 1'b1; start_pc = 8'd0; redirect = 1'b1; redirect_pc = 8'd66;
    tick();
    start = 1'b0; redirect = 1'b0;
    check("idle_rd_addr", 32'(imem_addr0), 32'd64);
    wait_idle(0, n);
    tick();
    check("idle_rd_done", 32'(done_cnt0 - d), 32'd1);
    check("idle_rd_count", 32'(fetch_count0), 32'd4);
    check("idle_rd_sb_empty", 32'(q0.size()), 32'd0);

    // Address wrap on the DEPTH=4, LAST_ADDR=4 instance.
    reset1 = 1'b0;
    tick();
    d = done_cnt1;
    expect_seq(1, 8'd252, 8'd4);
    start1 = 1'b1; start_pc1 = 8'd252;
    tick();
    start1 = 1'b0;
    repeat (5) tick();
    check("wr_busy_end", 32'(busy1), 32'd1);
    check("wr_addr_hold", 32'(imem_addr1), 32'd8);
    check("wr_head", 32'(out_pc1), 32'd252);
    out_ready1 = 1'b1;
    wait_idle(1, n);
    tick();
    check("wr_done", 32'(done_cnt1 - d), 32'd1);
    check("wr_count", 32'(fetch_count1), 32'd3);
    check("wr_sb_empty", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
